// File: rtl/riscv_dm_abstract_ctrl.sv
// riscv_dm_abstract_ctrl: abstract-command front end of the RISC-V debug module.
// Terminates DMI accesses to DATA, PROGBUF, ABSTRACTCS and COMMAND and
// sequences accepted access-register commands to the selected hart.
// Optional feature macro: RISCV_DM_AUTOEXEC_EN (ABSTRACTAUTO at 0x18 plus
// automatic re-issue of the last command on DATA/PROGBUF accesses).
module riscv_dm_abstract_ctrl #(
    parameter int unsigned DATACOUNT   = 2,
    parameter int unsigned PROGBUFSIZE = 8,
    parameter int unsigned XLEN        = 64
) (
    input  logic                                              clk_i,
    input  logic                                              rstn_i,
    input  logic                                              dmactive_i,
    input  logic                                              req_valid_i,
    output logic                                              req_ready_o,
    input  logic [1:0]                                        req_op_i,
    input  logic [6:0]                                        req_addr_i,
    input  logic [31:0]                                       req_data_i,
    output logic                                              resp_valid_o,
    output logic [1:0]                                        resp_op_o,
    output logic [31:0]                                       resp_data_o,
    input  logic                                              hart_halted_i,
    output logic                                              cmd_valid_o,
    input  logic                                              cmd_ready_i,
    output logic [31:0]                                       cmd_o,
    input  logic                                              cmd_done_i,
    input  logic                                              cmd_error_i,
    output logic [32*DATACOUNT-1:0]                           data_o,
    output logic [32*((PROGBUFSIZE > 0) ? PROGBUFSIZE : 1)-1:0] progbuf_o,
    input  logic                                              data_we_i,
    input  logic [3:0]                                        data_idx_i,
    input  logic [31:0]                                       data_wdata_i
);

    localparam int unsigned PBW         = (PROGBUFSIZE > 0) ? PROGBUFSIZE : 1;
    localparam logic [2:0]  MAX_AARSIZE = (XLEN == 64) ? 3'd3 : 3'd2;

    localparam logic [1:0]  OP_RD       = 2'd1;
    localparam logic [1:0]  OP_WR       = 2'd2;
    localparam logic [1:0]  RSP_SUCCESS = 2'd0;

    localparam logic [6:0]  A_DATA0     = 7'h04;
    localparam logic [6:0]  A_DATA_END  = 7'(4 + DATACOUNT);
    localparam logic [6:0]  A_ABSCS     = 7'h16;
    localparam logic [6:0]  A_COMMAND   = 7'h17;
    localparam logic [6:0]  A_PB0       = 7'h20;
    localparam logic [6:0]  A_PB_END    = 7'(32 + PROGBUFSIZE);

    localparam logic [2:0]  ERR_NONE    = 3'd0;
    localparam logic [2:0]  ERR_BUSY    = 3'd1;
    localparam logic [2:0]  ERR_NOTSUP  = 3'd2;
    localparam logic [2:0]  ERR_EXC     = 3'd3;
    localparam logic [2:0]  ERR_HALT    = 3'd4;

`ifdef RISCV_DM_AUTOEXEC_EN
    localparam logic [6:0]  A_AUTO      = 7'h18;
    localparam logic [11:0] AUTO_D_MASK = 12'((1 << DATACOUNT) - 1);
    localparam logic [15:0] AUTO_P_MASK = 16'((1 << PROGBUFSIZE) - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t      r_state;
    logic [31:0] r_data [DATACOUNT];
    logic [31:0] r_progbuf [PBW];
    logic [2:0]  r_cmderr;
    logic [31:0] r_cmd;
    logic        r_cmd_valid;
    logic        r_resp_valid;
    logic [1:0]  r_resp_op;
    logic [31:0] r_resp_data;
`ifdef RISCV_DM_AUTOEXEC_EN
    logic [11:0] r_auto_data;
    logic [15:0] r_auto_pb;
`endif

    logic        w_busy;
    logic        w_acc;
    logic        w_rd;
    logic        w_wr;
    logic        w_hit_data;
    logic        w_hit_pb;
    logic        w_access;
    logic        w_cmd_wr;
    logic        w_auto_hit;
    logic        w_busy_err;
    logic        w_try;
    logic        w_launch;
    logic [6:0]  w_data_off;
    logic [6:0]  w_pb_off;
    logic [31:0] w_rdata;
    logic [31:0] w_try_word;
    logic [2:0]  w_chk;
    logic [2:0]  w_cmderr_nxt;

    // Access-register command legality; first failing rule decides the error
    function automatic logic [2:0] f_check(input logic [31:0] c, input logic halted);
        logic [2:0] e;
        if (c[31:24] != 8'h00)                      e = ERR_NOTSUP;
        else if ((c[22:20] > MAX_AARSIZE) || c[19]) e = ERR_NOTSUP;
        else if (c[18] && (PROGBUFSIZE == 0))       e = ERR_NOTSUP;
        else if (!halted)                           e = ERR_HALT;
        else                                        e = ERR_NONE;
        return e;
    endfunction

    // Response is a one-cycle pulse, so a new request can always be taken
    assign req_ready_o  = rstn_i;
    assign resp_valid_o = r_resp_valid;
    assign resp_op_o    = r_resp_op;
    assign resp_data_o  = r_resp_data;
    assign cmd_valid_o  = r_cmd_valid;
    assign cmd_o        = r_cmd;

    // Flatten register files onto the output buses
    always_comb begin
        data_o    = '0;
        progbuf_o = '0;
        for (int unsigned i = 0; i < DATACOUNT; i++) data_o[32*i +: 32] = r_data[i];
        for (int unsigned i = 0; i < PBW; i++)       progbuf_o[32*i +: 32] = r_progbuf[i];
    end

    // Request decode, busy/command checks and next cmderr
    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_acc      = req_valid_i && req_ready_o;
        w_rd       = w_acc && (req_op_i == OP_RD);
        w_wr       = w_acc && (req_op_i == OP_WR);
        w_data_off = req_addr_i - A_DATA0;
        w_pb_off   = req_addr_i - A_PB0;
        w_hit_data = (req_addr_i >= A_DATA0) && (req_addr_i < A_DATA_END);
        w_hit_pb   = (req_addr_i >= A_PB0) && (req_addr_i < A_PB_END);
        w_access   = (w_rd || w_wr) && (w_hit_data || w_hit_pb);
        w_cmd_wr   = w_wr && (req_addr_i == A_COMMAND);

        w_auto_hit = 1'b0;
`ifdef RISCV_DM_AUTOEXEC_EN
        for (int unsigned i = 0; i < DATACOUNT; i++)
            if (w_hit_data && (w_data_off == 7'(i)) && r_auto_data[i]) w_auto_hit = 1'b1;
        for (int unsigned i = 0; i < PROGBUFSIZE; i++)
            if (w_hit_pb && (w_pb_off == 7'(i)) && r_auto_pb[i]) w_auto_hit = 1'b1;
`endif

        w_busy_err = w_busy && (w_access || w_cmd_wr);
        w_try      = !w_busy && (w_cmd_wr || (w_access && w_auto_hit));
        w_try_word = w_cmd_wr ? req_data_i : r_cmd;
        w_chk      = f_check(w_try_word, hart_halted_i);
        w_launch   = w_try && (r_cmderr == ERR_NONE) && (w_chk == ERR_NONE);

        w_cmderr_nxt = r_cmderr;
        if (w_wr && (req_addr_i == A_ABSCS)) w_cmderr_nxt = r_cmderr & ~req_data_i[10:8];
        if (w_busy_err && (r_cmderr == ERR_NONE)) w_cmderr_nxt = ERR_BUSY;
        if (w_try && (r_cmderr == ERR_NONE) && (w_chk != ERR_NONE)) w_cmderr_nxt = w_chk;
        // Hart exception is applied last so it overrides a same-cycle DMI effect
        if ((r_state == S_WAIT) && cmd_done_i && cmd_error_i) w_cmderr_nxt = ERR_EXC;
    end

    // Read data mux, sampled from pre-update state
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < DATACOUNT; i++)
            if (w_hit_data && (w_data_off == 7'(i))) w_rdata = r_data[i];
        for (int unsigned i = 0; i < PROGBUFSIZE; i++)
            if (w_hit_pb && (w_pb_off == 7'(i))) w_rdata = r_progbuf[i];
        if (req_addr_i == A_ABSCS)
            w_rdata = {3'b000, 5'(PROGBUFSIZE), 11'b0, w_busy, 1'b0, r_cmderr,
                       4'b0000, 4'(DATACOUNT)};
`ifdef RISCV_DM_AUTOEXEC_EN
        if (req_addr_i == A_AUTO) w_rdata = {r_auto_pb, 4'b0000, r_auto_data};
`endif
    end

    // Register file, response pipeline and command sequencer
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= S_IDLE;
            r_cmderr     <= ERR_NONE;
            r_cmd        <= '0;
            r_cmd_valid  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_op    <= RSP_SUCCESS;
            r_resp_data  <= '0;
            for (int unsigned i = 0; i < DATACOUNT; i++) r_data[i] <= '0;
            for (int unsigned i = 0; i < PBW; i++)       r_progbuf[i] <= '0;
`ifdef RISCV_DM_AUTOEXEC_EN
            r_auto_data  <= '0;
            r_auto_pb    <= '0;
`endif
        end else if (!dmactive_i) begin
            r_state      <= S_IDLE;
            r_cmderr     <= ERR_NONE;
            r_cmd        <= '0;
            r_cmd_valid  <= 1'b0;
            r_resp_valid <= w_acc;
            r_resp_op    <= RSP_SUCCESS;
            r_resp_data  <= '0;
            for (int unsigned i = 0; i < DATACOUNT; i++) r_data[i] <= '0;
            for (int unsigned i = 0; i < PBW; i++)       r_progbuf[i] <= '0;
`ifdef RISCV_DM_AUTOEXEC_EN
            r_auto_data  <= '0;
            r_auto_pb    <= '0;
`endif
        end else begin
            r_resp_valid <= w_acc;
            r_resp_op    <= RSP_SUCCESS;
            r_resp_data  <= w_rd ? w_rdata : '0;
            r_cmderr     <= w_cmderr_nxt;

            for (int unsigned i = 0; i < DATACOUNT; i++) begin
                if (data_we_i && (data_idx_i == 4'(i)))
                    r_data[i] <= data_wdata_i;
                else if (w_wr && w_hit_data && !w_busy && (w_data_off == 7'(i)))
                    r_data[i] <= req_data_i;
            end
            for (int unsigned i = 0; i < PROGBUFSIZE; i++)
                if (w_wr && w_hit_pb && !w_busy && (w_pb_off == 7'(i)))
                    r_progbuf[i] <= req_data_i;
`ifdef RISCV_DM_AUTOEXEC_EN
            if (w_wr && (req_addr_i == A_AUTO)) begin
                r_auto_data <= req_data_i[11:0] & AUTO_D_MASK;
                r_auto_pb   <= req_data_i[31:16] & AUTO_P_MASK;
            end
`endif

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_cmd       <= w_try_word;
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready_i) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cmd_done_i) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dm_abstract_ctrl.sv
// Self-checking bench for riscv_dm_abstract_ctrl: directed literal checks
// followed by randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_riscv_dm_abstract_ctrl;

    localparam int DC = 2;
    localparam int PB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, dmactive, req_valid, req_ready, resp_valid;
    logic [1:0]  req_op, resp_op;
    logic [6:0]  req_addr;
    logic [31:0] req_data, resp_data;
    logic        halted, cmd_valid, cmd_ready, done, err;
    logic [31:0] cmd;
    logic [32*DC-1:0] data_o;
    logic [32*PB-1:0] pb_o;
    logic        dwe;
    logic [3:0]  didx;
    logic [31:0] dwdata;

    // second instance, XLEN=32, used only for the aarsize limit
    logic        s_req_valid, s_req_ready, s_resp_valid, s_cmd_valid;
    logic [1:0]  s_req_op, s_resp_op;
    logic [6:0]  s_req_addr;
    logic [31:0] s_req_data, s_resp_data, s_cmd;
    logic [32*DC-1:0] s_data_o;
    logic [32*PB-1:0] s_pb_o;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    riscv_dm_abstract_ctrl #(.DATACOUNT(DC), .PROGBUFSIZE(PB), .XLEN(64)) dut (
        .clk_i(clk), .rstn_i(rstn), .dmactive_i(dmactive),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .resp_valid_o(resp_valid), .resp_op_o(resp_op), .resp_data_o(resp_data),
        .hart_halted_i(halted), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
        .cmd_o(cmd), .cmd_done_i(done), .cmd_error_i(err),
        .data_o(data_o), .progbuf_o(pb_o),
        .data_we_i(dwe), .data_idx_i(didx), .data_wdata_i(dwdata)
    );

    riscv_dm_abstract_ctrl #(.DATACOUNT(DC), .PROGBUFSIZE(PB), .XLEN(32)) dut32 (
        .clk_i(clk), .rstn_i(rstn), .dmactive_i(1'b1),
        .req_valid_i(s_req_valid), .req_ready_o(s_req_ready), .req_op_i(s_req_op),
        .req_addr_i(s_req_addr), .req_data_i(s_req_data),
        .resp_valid_o(s_resp_valid), .resp_op_o(s_resp_op), .resp_data_o(s_resp_data),
        .hart_halted_i(1'b1), .cmd_valid_o(s_cmd_valid), .cmd_ready_i(1'b0),
        .cmd_o(s_cmd), .cmd_done_i(1'b0), .cmd_error_i(1'b0),
        .data_o(s_data_o), .progbuf_o(s_pb_o),
        .data_we_i(1'b0), .data_idx_i(4'd0), .data_wdata_i(32'd0)
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_data [DC];
    logic [31:0] m_pb [PB];
    int          m_cerr;
    bit          m_pend, m_offer;    // command outstanding / still offered to hart
    logic [31:0] m_cmd, m_rdata;
    bit          m_rv;
    logic [11:0] m_auto_d;
    logic [15:0] m_auto_p;

    function automatic logic [31:0] mread(input logic [6:0] a);
        int ai = int'(a);
        if (ai >= 4 && ai < 4 + DC)   return m_data[ai-4];
        if (ai >= 32 && ai < 32 + PB) return m_pb[ai-32];
        if (ai == 'h16) return 32'((PB << 24) | (int'(m_pend) << 12) | (m_cerr << 8) | DC);
`ifdef RISCV_DM_AUTOEXEC_EN
        if (ai == 'h18) return {m_auto_p, 4'h0, m_auto_d};
`endif
        return 32'h0;
    endfunction

    function automatic int mcheck(input logic [31:0] c, input logic h);
        int sz = int'(c[22:20]);
        if (c[31:24] != 0 || sz > 3 || c[19]) return 2;
        if (c[18] && PB == 0) return 2;
        if (!h) return 4;
        return 0;
    endfunction

    task automatic mclear();
        for (int i = 0; i < DC; i++) m_data[i] = '0;
        for (int i = 0; i < PB; i++) m_pb[i] = '0;
        m_cerr = 0; m_pend = 0; m_offer = 0; m_cmd = '0;
        m_auto_d = '0; m_auto_p = '0;
    endtask

    int  ai, ce, e;
    bit  busy, old_pend, old_offer, acc, is_mem, autohit, start, is_wr;
    logic [31:0] nc;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mclear(); m_rv = 0; m_rdata = '0;
        end else begin
            acc = req_valid;
            ai = int'(req_addr);
            is_wr = acc && (req_op == 2);
            busy = m_pend; old_pend = m_pend; old_offer = m_offer;
            m_rv = acc;
            m_rdata = (acc && req_op == 1 && dmactive) ? mread(req_addr) : 32'h0;
            if (!dmactive) mclear();
            else begin
                ce = m_cerr; start = 0; nc = m_cmd;
                is_mem = acc && (req_op == 1 || req_op == 2) &&
                         ((ai >= 4 && ai < 4 + DC) || (ai >= 32 && ai < 32 + PB));
                autohit = 0;
`ifdef RISCV_DM_AUTOEXEC_EN
                if (ai >= 4 && ai < 4 + DC && m_auto_d[ai-4]) autohit = 1;
                if (ai >= 32 && ai < 32 + PB && m_auto_p[ai-32]) autohit = 1;
                if (is_wr && ai == 'h18) begin
                    m_auto_d = req_data[11:0] & 12'((1 << DC) - 1);
                    m_auto_p = req_data[31:16] & 16'((1 << PB) - 1);
                end
`endif
                if (is_mem && busy) begin
                    if (ce == 0) ce = 1;
                end else if (is_wr && ai >= 4 && ai < 4 + DC) m_data[ai-4] = req_data;
                else if (is_wr && ai >= 32 && ai < 32 + PB) m_pb[ai-32] = req_data;
                if (is_wr && ai == 'h16) ce = ce & ~int'(req_data[10:8]);
                if (is_wr && ai == 'h17) begin
                    if (busy) begin
                        if (ce == 0) ce = 1;
                    end else if (ce == 0) begin
                        e = mcheck(req_data, halted);
                        if (e != 0) ce = e; else begin start = 1; nc = req_data; end
                    end
                end else if (is_mem && autohit && !busy && ce == 0) begin
                    e = mcheck(m_cmd, halted);
                    if (e != 0) ce = e; else begin start = 1; nc = m_cmd; end
                end
                if (dwe && int'(didx) < DC) m_data[didx] = dwdata;
                if (old_pend && old_offer && cmd_ready) m_offer = 0;
                if (old_pend && !old_offer && done) begin
                    m_pend = 0;
                    if (err) ce = 3;
                end
                if (start) begin m_pend = 1; m_offer = 1; m_cmd = nc; end
                m_cerr = ce;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    logic [32*DC-1:0] exp_d;
    logic [32*PB-1:0] exp_p;
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < DC; i++) exp_d[32*i +: 32] = m_data[i];
            for (int i = 0; i < PB; i++) exp_p[32*i +: 32] = m_pb[i];
            check("req_ready", req_ready, 1'b1);
            check("resp_valid", resp_valid, m_rv);
            if (m_rv) begin
                check("resp_op", resp_op, 2'd0);
                check("resp_data", resp_data, m_rdata);
            end
            check("cmd_valid", cmd_valid, m_pend && m_offer);
            if (m_pend && m_offer) check("cmd_o", cmd, m_cmd);
            check("data_o", data_o, exp_d);
            check("progbuf_o", pb_o, exp_p);
        end
    end

    // ---------------- stimulus ----------------
    task automatic dmi(input bit sel, input logic [1:0] op, input logic [6:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        if (sel) begin s_req_valid = 1; s_req_op = op; s_req_addr = a; s_req_data = d; end
        else     begin req_valid = 1; req_op = op; req_addr = a; req_data = d; end
        @(negedge clk);
        rd = sel ? s_resp_data : resp_data;
        if (sel) s_req_valid = 0; else req_valid = 0;
    endtask

    task automatic pulse_ready();
        @(negedge clk); cmd_ready = 1;
        @(negedge clk); cmd_ready = 0;
    endtask

    task automatic pulse_done(input logic e_in);
        @(negedge clk); done = 1; err = e_in;
        @(negedge clk); done = 0; err = 0;
    endtask

    logic [6:0]  addrs [11] = '{7'h04, 7'h05, 7'h06, 7'h16, 7'h17, 7'h18,
                                7'h20, 7'h27, 7'h28, 7'h10, 7'h17};
    logic [31:0] cmds [7]   = '{32'h00321000, 32'h00221005, 32'h01000000, 32'h00421000,
                                32'h00380000, 32'h00261000, 32'h00041000};

    logic [31:0] r;
    int sel_op;
    initial begin
        rstn = 0; dmactive = 1; req_valid = 0; req_op = 0; req_addr = 0; req_data = 0;
        halted = 1; cmd_ready = 0; done = 0; err = 0; dwe = 0; didx = 0; dwdata = 0;
        s_req_valid = 0; s_req_op = 0; s_req_addr = 0; s_req_data = 0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_data", data_o, '0);
        rstn = 1;
        @(posedge clk); cmp_en = 1;

        dmi(0, 2'd1, 7'h16, 0, r);            check("abscs_reset", r, 32'h08000002);
        dmi(0, 2'd2, 7'h17, 32'h00321000, r);
        check("issue_valid", cmd_valid, 1'b1);
        check("issue_cmd", cmd, 32'h00321000);
        dmi(0, 2'd1, 7'h16, 0, r);            check("abscs_busy", r, 32'h08001002);
        pulse_ready();
        dmi(0, 2'd2, 7'h04, 32'h1234, r);
        dmi(0, 2'd1, 7'h16, 0, r);            check("abscs_busyerr", r, 32'h08001102);
        pulse_done(0);
        dmi(0, 2'd1, 7'h16, 0, r);            check("abscs_done", r, 32'h08000102);
        dmi(0, 2'd1, 7'h04, 0, r);            check("data0_kept", r, 32'h0);
        dmi(0, 2'd2, 7'h17, 32'h00321000, r); check("cmd_ignored", cmd_valid, 1'b0);
        dmi(0, 2'd2, 7'h16, 32'h700, r);
        dmi(0, 2'd1, 7'h16, 0, r);            check("abscs_cleared", r, 32'h08000002);
        dmi(0, 2'd2, 7'h17, 32'h01000000, r); check("cmdtype_novalid", cmd_valid, 1'b0);
        dmi(0, 2'd1, 7'h16, 0, r);            check("abscs_cmdtype", r, 32'h08000202);
        dmi(0, 2'd2, 7'h16, 32'h700, r);
        halted = 0;
        dmi(0, 2'd2, 7'h17, 32'h00321000, r); check("nohalt_novalid", cmd_valid, 1'b0);
        dmi(0, 2'd1, 7'h16, 0, r);            check("abscs_nohalt", r, 32'h08000402);
        halted = 1;
        dmi(0, 2'd2, 7'h16, 32'h700, r);
        @(negedge clk); dwe = 1; didx = 1; dwdata = 32'hdeadbeef;
        @(negedge clk); dwe = 0;
        dmi(0, 2'd1, 7'h05, 0, r);            check("data1_hart", r, 32'hdeadbeef);
        @(negedge clk); dwe = 1; didx = 5; dwdata = 32'h55;
        @(negedge clk); dwe = 0;
        check("data_idx5_ignored", data_o, 64'hdeadbeef_00000000);
        dmi(0, 2'd2, 7'h17, 32'h00221005, r);
        pulse_ready();
        pulse_done(1);
        dmi(0, 2'd1, 7'h16, 0, r);            check("abscs_exc", r, 32'h08000302);
        dmi(0, 2'd2, 7'h16, 32'h700, r);
        dmi(0, 2'd2, 7'h17, 32'h00321000, r);
        pulse_ready();
        @(negedge clk); dmactive = 0;
        dmi(0, 2'd1, 7'h16, 0, r);            check("inactive_read", r, 32'h0);
        check("inactive_data", data_o, '0);
        @(negedge clk); dmactive = 1; done = 1;
        @(negedge clk); done = 0;
        dmi(0, 2'd1, 7'h16, 0, r);            check("late_done", r, 32'h08000002);

        dmi(1, 2'd2, 7'h17, 32'h00300000, r); check("x32_novalid", s_cmd_valid, 1'b0);
        dmi(1, 2'd1, 7'h16, 0, r);            check("x32_abscs", r, 32'h08000202);
        dmi(1, 2'd2, 7'h16, 32'h700, r);
        dmi(1, 2'd2, 7'h17, 32'h00221000, r); check("x32_valid", s_cmd_valid, 1'b1);
        check("x32_cmd", s_cmd, 32'h00221000);

`ifdef RISCV_DM_AUTOEXEC_EN
        dmi(0, 2'd2, 7'h17, 32'h00321000, r);
        pulse_ready();
        pulse_done(0);
        dmi(0, 2'd2, 7'h18, 32'h1, r);
        dmi(0, 2'd1, 7'h04, 0, r);            check("auto_valid", cmd_valid, 1'b1);
        check("auto_cmd", cmd, 32'h00321000);
        pulse_ready();
        pulse_done(0);
`endif

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 2) != 0);
            sel_op    = $urandom_range(0, 9);
            req_op    = (sel_op == 0) ? 2'd0 : (sel_op <= 4) ? 2'd1 : (sel_op <= 8) ? 2'd2 : 2'd3;
            req_addr  = addrs[$urandom_range(0, 10)];
            if (req_addr == 7'h16)      req_data = $urandom_range(0, 1) ? 32'h700 : $urandom;
            else if (req_addr == 7'h17) req_data = cmds[$urandom_range(0, 6)];
            else                        req_data = $urandom;
            cmd_ready = $urandom_range(0, 1);
            done      = ($urandom_range(0, 3) == 0);
            err       = ($urandom_range(0, 3) == 0);
            halted    = ($urandom_range(0, 9) != 0);
            dmactive  = ($urandom_range(0, 99) >= 2);
            dwe       = ($urandom_range(0, 7) == 0);
            didx      = 4'($urandom_range(0, 3));
            dwdata    = $urandom;
        end
        @(negedge clk);
        req_valid = 0; cmd_ready = 0; done = 0; err = 0; dwe = 0; dmactive = 1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_dm_abstract_ctrl.md
Name: riscv_dm_abstract_ctrl

Overview:
Parametrised abstract-command front end of the debug module. It terminates DMI register accesses for DATA0..DATAn, PROGBUF0..PROGBUFm, ABSTRACTCS and COMMAND, and checks access-register commands. It sequences each accepted command to the selected hart through a valid/ready plus completion handshake. It sits between the DMI request decoder and the hart debug interface, and generalises the fixed register map to configurable data/progbuf counts and XLEN.

Parameters:
DATACOUNT, 2, number of DATA registers (1..12), mapped at 0x04 + i
PROGBUFSIZE, 8, number of PROGBUF words (0..16), mapped at 0x20 + i
XLEN, 64, hart register width (32 or 64); largest accepted aarsize is 2 (XLEN=32) or 3 (XLEN=64)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
dmactive_i  in  1  DMCONTROL.dmactive; low = synchronous soft reset of block state
req_valid_i  in  1  DMI request valid
req_ready_o  out  1  DMI request ready
req_op_i  in  2  WR_OP_NOP/RD/WR
req_addr_i  in  7  DMI register address
req_data_i  in  32  write data
resp_valid_o  out  1  response valid
resp_op_o  out  2  RD_OP_SUCCESS/FAILED
resp_data_o  out  32  read data
hart_halted_i  in  1  selected hart halted
cmd_valid_o  out  1  command to hart valid
cmd_ready_i  in  1  hart accepts command
cmd_o  out  32  command_t payload
cmd_done_i  in  1  one-cycle completion pulse
cmd_error_i  in  1  exception during command; qualified by cmd_done_i
data_o  out  32*DATACOUNT  DATA registers, flat, DATA0 in LSBs
progbuf_o  out  32*max(PROGBUFSIZE,1)  PROGBUF words, flat
data_we_i  in  1  hart writes a DATA register (result of a read transfer)
data_idx_i  in  4  index of the DATA register written
data_wdata_i  in  32  value written

Behaviour:
- Reset (rstn_i=0): all DATA/PROGBUF=0, cmderr=0, busy=0, FSM=IDLE, cmd_valid_o=0, resp_valid_o=0, resp_op_o=0, resp_data_o=0, req_ready_o=0 during reset.
- dmactive_i=0: same clearing, applied synchronously. An outstanding hart completion is ignored. req_ready_o stays 1, all reads return 0, writes are dropped.
- req_ready_o=1 whenever resp_valid_o=0 or the response is consumed in the same cycle (resp has no ready; it is a one-cycle pulse). A request is accepted on valid&&ready. The response follows exactly 1 cycle later.
- NOP: response SUCCESS, data 0.
- Unmapped address: read returns 0 with SUCCESS; write is ignored.
- ABSTRACTCS read: progbufsize=PROGBUFSIZE, busy, cmderr, datacount=DATACOUNT, all other fields 0.
- ABSTRACTCS write: cmderr is write-1-to-clear, bitwise on [10:8].
- Writes to DATA, PROGBUF or COMMAND while busy=1: register unchanged; if cmderr==0, set cmderr=1 (BUSY). Reads while busy behave the same way for DATA/PROGBUF.
- COMMAND write is ignored when cmderr!=0. Otherwise, in order:
  - cmdtype!=0 -> cmderr=2
  - aarsize>max, or aarpostincrement=1 -> cmderr=2
  - postexec=1 with PROGBUFSIZE=0 -> cmderr=2
  - hart_halted_i=0 -> cmderr=4
  - else latch the command, busy=1, FSM IDLE->ISSUE
- FSM:
  - IDLE: busy=0.
  - ISSUE: cmd_valid_o=1 holding the latched command until cmd_ready_i; then go to WAIT.
  - WAIT: on cmd_done_i go to IDLE, busy=0; if cmd_error_i then cmderr=3.
  - cmd_done_i outside WAIT is ignored.
- data_we_i updates DATA[data_idx_i] in any state. Indices >= DATACOUNT are ignored. If data_we_i and a DMI write hit the same register in the same cycle, data_we_i wins.
- Busy check uses the busy value before the current cycle's write.

Optional Feature:
RISCV_DM_AUTOEXEC_EN:
- Defined: adds ABSTRACTAUTO (0x18) with autoexecdata[DATACOUNT-1:0] at bits [11:0] and autoexecprogbuf[PROGBUFSIZE-1:0] at bits [31:16]. A DMI read or write of DATAi/PROGBUFi whose autoexec bit is set re-issues the last latched command with identical checks; the data write occurs first. Under the busy rule the access sets cmderr=1 instead.
- Undefined: 0x18 is unmapped (reads 0) and no auto re-issue occurs.

Test Plan:
- DATACOUNT=2, PROGBUFSIZE=8: read ABSTRACTCS -> resp_data_o=0x08000002, SUCCESS, 1 cycle after acceptance.
- hart_halted_i=1, write COMMAND=0x00321000 (XLEN=64) -> busy=1; cmd_valid_o until cmd_ready_i with cmd_o=0x00321000; cmd_done_i -> busy=0, cmderr=0.
- During WAIT, write DATA0=0x1234 -> DATA0 unchanged, cmderr=1. Further command ignored until ABSTRACTCS write 0x00000700 -> cmderr=0.
- COMMAND=0x01000000 -> cmderr=2. With XLEN=32, COMMAND=0x00300000 -> cmderr=2. hart_halted_i=0 with a valid command -> cmderr=4. No cmd_valid_o in any case.
- cmd_done_i with cmd_error_i=1 -> cmderr=3. data_we_i idx=1 value 0xdeadbeef -> DATA1 reads 0xdeadbeef. idx=5 -> no change.
- dmactive_i=0 mid-WAIT -> busy=0, DATA=0, late cmd_done_i ignored. With RISCV_DM_AUTOEXEC_EN, autoexecdata[0]=1 and a read of DATA0 -> command re-issued.
